sparc_trap_ctrl: RTL and testbench
==================================

Name: sparc_trap_ctrl

Overview:
- Per-thread trap collection and dispatch unit for the multithreaded SPARC V8 integer pipeline.
- Accepts at most one exception report per cycle, tagged with a thread ID, and keeps one pending trap per thread.
- When a thread gets a second report, the entry keeps whichever trap has the higher SPARC V8 priority.
- Round-robin arbitration presents one 8-bit trap type per handshake to the trap-handling microcode stage, and flags error mode when the thread has ET=0.

Parameters:
- NTHREAD, 64: number of hardware threads; power of two, 2..64.
- TIDW, $clog2(NTHREAD): thread ID width.

Ports:
- gclk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- exc_valid  in  1  exception report strobe.
- exc_tid  in  TIDW  reporting thread.
- exc_tt  in  6  trap_type code from the shared package.
- exc_swtn  in  7  Ticc software trap number; used only when exc_tt==TT_TICC.
- flush_valid  in  1  discard the pending trap of flush_tid.
- flush_tid  in  TIDW  thread to flush.
- et  in  NTHREAD  per-thread PSR.ET.
- trap_valid  out  1  trap offered to the handler.
- trap_ready  in  1  handler accepts.
- trap_tid  out  TIDW  thread of the offered trap.
- trap_tt  out  8  full SPARC TT value.
- trap_err  out  1  thread had ET=0 at selection; enter error mode.
- pend_vec  out  NTHREAD  per-thread pending flags, table only.

Behaviour:
- Reset (any cycle, including mid-handshake):
  - all table entries invalid; pend_vec=0.
  - trap_valid=0, trap_tid=0, trap_tt=0, trap_err=0.
  - round-robin pointer = 0.
- Table entry: {v, tt[5:0], swtn[6:0]}.
- Report update at gclk:
  - entry invalid: install the report.
  - entry valid: replace it only if prio(exc_tt) is strictly lower (numerically) than prio(stored tt); on equal priority keep the stored trap.
- Priority numbers (lower wins):
  - IAEX 5, PRIV 6, IINST 7, FPDIS 8, CPDIS 8, WINOF 9, WINUF 9, UNALA 10, FPEXC 11, DAEX 13, TAG 14, DIVZ 15, TICC 16.
  - Any other code: 31.
- Arbitration:
  - The output register loads when trap_valid==0, or when trap_valid && trap_ready.
  - Selection is the first valid entry at or after the pointer, wrapping modulo NTHREAD.
  - On load, the selected entry is cleared and the pointer moves to selected tid+1, wrapping.
  - If no entry is valid, trap_valid goes to 0.
- Output mapping:
  - trap_tt = 8'h80 | swtn when tt==TT_TICC; otherwise {2'b00, tt}.
  - trap_err = ~et[tid], sampled at load.
- Output stability: trap_tid, trap_tt and trap_err hold steady while trap_valid && !trap_ready. A higher-priority report for the held thread does not alter the offer; it is installed in the table as a new entry.
- Latency:
  - Report at cycle N: entry valid at N+1.
  - Earliest trap_valid at N+2.
  - Back-to-back accepts give one trap per cycle.
- Same-thread collisions within one cycle, in this order: selection-clear, then flush, then report.
  - Selection-clear and report for the same tid: report installs into the emptied entry.
  - Flush and report for the same tid: the report survives.
  - Flush never cancels the held output register.
- pend_vec reflects table entries only, excluding the held output.

Optional Feature:
- Macro: SPARC_TRAP_CNT_EN.
- When defined:
  - adds per-thread 16-bit saturating counters, incremented on each accepted trap (trap_valid && trap_ready) of that thread; stuck at 16'hFFFF.
  - ports cnt_tid (in, TIDW) and cnt_data (out, 16) give a registered read with one-cycle latency.
  - rst clears all counters.
- When undefined: the counters and these two ports are absent; all other behaviour is identical.

Decomposition:
- Shared package additions:
  - trap_prio_type (5-bit).
  - function trap_prio(trap_type) returning the numbers above.
  - function trap_tt8(trap_type, swtn).
  - constant TT_TICC_BASE = 8'h80.
  - struct trap_entry_type.
- One sub-module, sparc_rr_arbiter: parametrised NTHREAD request vector plus pointer, producing grant tid and a found flag, purely combinational. Pointer state stays in sparc_trap_ctrl.

Test Plan:
- Report tid=3 tt=TT_DIVZ with et[3]=1, trap_ready=1 -> two cycles later trap_valid=1, trap_tid=3, trap_tt=8'h2A, trap_err=0; pend_vec[3] is 1 for one cycle then 0.
- Report tid=5 TT_DAEX, then next cycle tid=5 TT_IINST, with trap_ready=0 held off -> a single trap_tt=8'h02 for tid 5. Repeating TT_WINOF after a stored TT_WINUF keeps 8'h06.
- Report tid=7 TT_TICC swtn=7'h05 with et[7]=0 -> trap_tt=8'h85, trap_err=1.
- Pending on tids 1, 2 and 60 with the pointer at 2 and trap_ready always 1 -> grant order 2, 60, 1; pointer ends at 2.
- trap_valid held with trap_ready=0 for 5 cycles while tid 9 gets a higher-priority report -> trap_tt stays stable; tid 9's new entry dispatches after the accept. Flush tid 9 in the same cycle as its report -> entry remains valid.
- rst asserted during trap_valid=1 -> next cycle trap_valid=0 and pend_vec=0. Under SPARC_TRAP_CNT_EN, 70000 accepts on tid 0 -> cnt_data=16'hFFFF.

Source files
------------

// File: rtl/sparc_trap_ctrl_pkg.sv
// Shared trap definitions for the SPARC V8 trap controller.
// Contents:
//   trap_type       6-bit trap code (low bits of the V8 TT value)
//   trap_prio_type  5-bit priority number, lower wins
//   trap_entry_type one pending-trap table entry {v, tt, swtn}
//   trap_prio()     priority lookup; unknown codes get the weakest priority
//   trap_tt8()      full 8-bit TT; Ticc maps to 8'h80 | swtn
package sparc_trap_ctrl_pkg;

  typedef enum logic [5:0] {
    TT_RESET = 6'h00,
    TT_IAEX  = 6'h01,
    TT_IINST = 6'h02,
    TT_PRIV  = 6'h03,
    TT_FPDIS = 6'h04,
    TT_WINOF = 6'h05,
    TT_WINUF = 6'h06,
    TT_UNALA = 6'h07,
    TT_FPEXC = 6'h08,
    TT_DAEX  = 6'h09,
    TT_TAG   = 6'h0A,
    TT_CPDIS = 6'h24,
    TT_CPEXC = 6'h28,
    TT_DIVZ  = 6'h2A,
    TT_TICC  = 6'h3F   // internal code only; the real TT comes from swtn
  } trap_type;

  typedef logic [4:0] trap_prio_type;

  localparam logic [7:0] TT_TICC_BASE = 8'h80;

  typedef struct packed {
    logic     v;
    trap_type tt;
    logic [6:0] swtn;
  } trap_entry_type;

  function automatic trap_prio_type trap_prio(input trap_type tt);
    case (tt)
      TT_IAEX:           return 5'd5;
      TT_PRIV:           return 5'd6;
      TT_IINST:          return 5'd7;
      TT_FPDIS, TT_CPDIS: return 5'd8;
      TT_WINOF, TT_WINUF: return 5'd9;
      TT_UNALA:          return 5'd10;
      TT_FPEXC:          return 5'd11;
      TT_DAEX:           return 5'd13;
      TT_TAG:            return 5'd14;
      TT_DIVZ:           return 5'd15;
      TT_TICC:           return 5'd16;
      default:           return 5'd31;
    endcase
  endfunction

  function automatic logic [7:0] trap_tt8(input trap_type tt, input logic [6:0] swtn);
    if (tt == TT_TICC) return TT_TICC_BASE | {1'b0, swtn};
    return {2'b00, tt};
  endfunction

endpackage

// File: rtl/sparc_trap_ctrl_rr_arbiter.sv
// sparc_rr_arbiter: combinational round-robin search.
// Ports:
//   req   in  NTHREAD  request vector
//   ptr   in  TIDW     search start position
//   gnt   out TIDW     first requester at or after ptr (wrapping)
//   found out 1        any requester present
// NTHREAD must be a power of two so ptr+i wraps for free.
module sparc_rr_arbiter #(
  parameter int NTHREAD = 64,
  parameter int TIDW    = $clog2(NTHREAD)
) (
  input  logic [NTHREAD-1:0] req,
  input  logic [TIDW-1:0]    ptr,
  output logic [TIDW-1:0]    gnt,
  output logic               found
);

  logic [TIDW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NTHREAD; i++) begin
      idx = ptr + TIDW'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

endmodule

// File: rtl/sparc_trap_ctrl.sv
// sparc_trap_ctrl: per-thread trap collection and round-robin dispatch.
// Ports:
//   gclk, rst                 clock, synchronous active-high reset
//   exc_valid/tid/tt/swtn     one exception report per cycle
//   flush_valid/tid           drop the pending table entry of a thread
//   et                        per-thread PSR.ET
//   trap_valid/ready          handshake to the trap microcode stage
//   trap_tid/tt/err           offered trap; err = thread had ET=0
//   pend_vec                  table valid bits (held offer excluded)
//   cnt_tid/cnt_data          registered per-thread accept counter read
//                             (only with SPARC_TRAP_CNT_EN defined)
// Optional feature macro: SPARC_TRAP_CNT_EN.
module sparc_trap_ctrl
  import sparc_trap_ctrl_pkg::*;
#(
  parameter int NTHREAD = 64,
  parameter int TIDW    = $clog2(NTHREAD)
) (
  input  logic               gclk,
  input  logic               rst,
  input  logic               exc_valid,
  input  logic [TIDW-1:0]    exc_tid,
  input  logic [5:0]         exc_tt,
  input  logic [6:0]         exc_swtn,
  input  logic               flush_valid,
  input  logic [TIDW-1:0]    flush_tid,
  input  logic [NTHREAD-1:0] et,
  output logic               trap_valid,
  input  logic               trap_ready,
  output logic [TIDW-1:0]    trap_tid,
  output logic [7:0]         trap_tt,
  output logic               trap_err,
`ifdef SPARC_TRAP_CNT_EN
  input  logic [TIDW-1:0]    cnt_tid,
  output logic [15:0]        cnt_data,
`endif
  output logic [NTHREAD-1:0] pend_vec
);

  trap_entry_type tbl     [NTHREAD];
  trap_entry_type tbl_nxt [NTHREAD];
  trap_entry_type e;
  logic [TIDW-1:0] ptr;
  logic [TIDW-1:0] gnt;
  logic            found;
  logic            load;
  trap_type        rep_tt;

  assign rep_tt = trap_type'(exc_tt);
  assign load   = !trap_valid || trap_ready;

  always_comb begin
    pend_vec = '0;
    for (int i = 0; i < NTHREAD; i++) pend_vec[i] = tbl[i].v;
  end

  sparc_rr_arbiter #(.NTHREAD(NTHREAD), .TIDW(TIDW)) u_arb (
    .req   (pend_vec),
    .ptr   (ptr),
    .gnt   (gnt),
    .found (found)
  );

  // Same-cycle ordering per entry: selection-clear, then flush, then report.
  // The report compares against the entry as left by the clears, so a
  // report always lands in an entry that was just emptied.
  always_comb begin
    e = '0;
    for (int i = 0; i < NTHREAD; i++) begin
      e = tbl[i];
      if (load && found && gnt == TIDW'(i)) e.v = 1'b0;
      if (flush_valid && flush_tid == TIDW'(i)) e.v = 1'b0;
      if (exc_valid && exc_tid == TIDW'(i)) begin
        if (!e.v || trap_prio(rep_tt) < trap_prio(e.tt)) begin
          e.v    = 1'b1;
          e.tt   = rep_tt;
          e.swtn = exc_swtn;
        end
      end
      tbl_nxt[i] = e;
    end
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      for (int i = 0; i < NTHREAD; i++) tbl[i] <= '0;
      ptr        <= '0;
      trap_valid <= 1'b0;
      trap_tid   <= '0;
      trap_tt    <= '0;
      trap_err   <= 1'b0;
    end else begin
      for (int i = 0; i < NTHREAD; i++) tbl[i] <= tbl_nxt[i];
      if (load) begin
        if (found) begin
          trap_valid <= 1'b1;
          trap_tid   <= gnt;
          trap_tt    <= trap_tt8(tbl[gnt].tt, tbl[gnt].swtn);
          trap_err   <= ~et[gnt];
          ptr        <= gnt + TIDW'(1);
        end else begin
          trap_valid <= 1'b0;
        end
      end
    end
  end

`ifdef SPARC_TRAP_CNT_EN
  logic [15:0] cnt [NTHREAD];

  always_ff @(posedge gclk) begin
    if (rst) begin
      for (int i = 0; i < NTHREAD; i++) cnt[i] <= '0;
      cnt_data <= '0;
    end else begin
      if (trap_valid && trap_ready && cnt[trap_tid] != 16'hFFFF)
        cnt[trap_tid] <= cnt[trap_tid] + 16'd1;
      cnt_data <= cnt[cnt_tid];
    end
  end
`endif

endmodule

// File: tb/tb_sparc_trap_ctrl.sv
// Directed bench for sparc_trap_ctrl (NTHREAD=64). Inputs change 1ns after
// the rising edge and outputs are checked at the same point.
module tb_sparc_trap_ctrl;
  import sparc_trap_ctrl_pkg::*;

  localparam int NTHREAD = 64;
  localparam int TIDW    = 6;

  logic               gclk = 1'b0;
  logic               rst;
  logic               exc_valid;
  logic [TIDW-1:0]    exc_tid;
  logic [5:0]         exc_tt;
  logic [6:0]         exc_swtn;
  logic               flush_valid;
  logic [TIDW-1:0]    flush_tid;
  logic [NTHREAD-1:0] et;
  logic               trap_valid;
  logic               trap_ready;
  logic [TIDW-1:0]    trap_tid;
  logic [7:0]         trap_tt;
  logic               trap_err;
  logic [NTHREAD-1:0] pend_vec;
`ifdef SPARC_TRAP_CNT_EN
  logic [TIDW-1:0]    cnt_tid;
  logic [15:0]        cnt_data;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 gclk = ~gclk;

  sparc_trap_ctrl #(.NTHREAD(NTHREAD), .TIDW(TIDW)) dut (
    .gclk        (gclk),
    .rst         (rst),
    .exc_valid   (exc_valid),
    .exc_tid     (exc_tid),
    .exc_tt      (exc_tt),
    .exc_swtn    (exc_swtn),
    .flush_valid (flush_valid),
    .flush_tid   (flush_tid),
    .et          (et),
    .trap_valid  (trap_valid),
    .trap_ready  (trap_ready),
    .trap_tid    (trap_tid),
    .trap_tt     (trap_tt),
    .trap_err    (trap_err),
`ifdef SPARC_TRAP_CNT_EN
    .cnt_tid     (cnt_tid),
    .cnt_data    (cnt_data),
`endif
    .pend_vec    (pend_vec)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic rep(input logic [TIDW-1:0] tid, input logic [5:0] tt, input logic [6:0] sw);
    exc_valid = 1'b1;
    exc_tid   = tid;
    exc_tt    = tt;
    exc_swtn  = sw;
  endtask

  task automatic noexc();
    exc_valid = 1'b0;
  endtask

  // {valid, tid, tt} packed for compact offer checks
  function automatic logic [63:0] offer(input logic v, input logic [TIDW-1:0] t, input logic [7:0] tt);
    return {49'b0, v, t, tt};
  endfunction

  initial begin
    rst = 1'b1; exc_valid = 0; exc_tid = '0; exc_tt = '0; exc_swtn = '0;
    flush_valid = 0; flush_tid = '0; trap_ready = 0;
    et = '1; et[7] = 1'b0;
`ifdef SPARC_TRAP_CNT_EN
    cnt_tid = '0;
`endif
    tick(); tick();
    chk("rst_offer", offer(trap_valid, trap_tid, trap_tt), 64'h0);
    chk("rst_err", trap_err, 0);
    chk("rst_pend", pend_vec, 64'h0);
    rst = 1'b0;

    // single DIVZ on tid 3
    trap_ready = 1;
    rep(3, TT_DIVZ, 0); tick(); noexc();
    chk("t1_pend", pend_vec, 64'h8);
    chk("t1_novalid", trap_valid, 0);
    tick();
    chk("t1_offer", offer(trap_valid, trap_tid, trap_tt), offer(1, 3, 8'h2A));
    chk("t1_err", trap_err, 0);
    chk("t1_pend0", pend_vec, 64'h0);
    tick();
    chk("t1_idle", trap_valid, 0);

    // priority merges while the output is busy with tid 4
    trap_ready = 0;
    rep(4, TT_TAG, 0); tick(); noexc(); tick();
    chk("t2_hold4", offer(trap_valid, trap_tid, trap_tt), offer(1, 4, 8'h0A));
    rep(5, TT_DAEX, 0);  tick();
    rep(5, TT_IINST, 0); tick();
    rep(6, TT_WINUF, 0); tick();
    rep(6, TT_WINOF, 0); tick();
    rep(8, 6'h11, 0);    tick();
    rep(8, TT_TAG, 0);   tick(); noexc();
    chk("t2_pend", pend_vec, 64'h160);
    chk("t2_still4", offer(trap_valid, trap_tid, trap_tt), offer(1, 4, 8'h0A));
    trap_ready = 1;
    tick(); chk("t2_tid5", offer(trap_valid, trap_tid, trap_tt), offer(1, 5, 8'h02));
    tick(); chk("t2_tid6", offer(trap_valid, trap_tid, trap_tt), offer(1, 6, 8'h06));
    tick(); chk("t2_tid8", offer(trap_valid, trap_tid, trap_tt), offer(1, 8, 8'h0A));
    tick(); chk("t2_idle", trap_valid, 0);

    // Ticc with ET=0
    rep(7, TT_TICC, 7'h05); tick(); noexc(); tick();
    chk("t3_offer", offer(trap_valid, trap_tid, trap_tt), offer(1, 7, 8'h85));
    chk("t3_err", trap_err, 1);
    tick(); chk("t3_idle", trap_valid, 0);

    // round robin: pointer parked at 2 by granting tid 1 first
    rst = 1; tick(); rst = 0;
    trap_ready = 0;
    rep(1, TT_DIVZ, 0); tick(); noexc(); tick();
    chk("t4_first1", offer(trap_valid, trap_tid, trap_tt), offer(1, 1, 8'h2A));
    rep(1, TT_TAG, 0);  tick();
    rep(2, TT_DIVZ, 0); tick();
    rep(60, TT_DAEX, 0); tick(); noexc();
    chk("t4_pend", pend_vec, 64'h1000_0000_0000_0006);
    trap_ready = 1;
    tick(); chk("t4_g2", offer(trap_valid, trap_tid, trap_tt), offer(1, 2, 8'h2A));
    tick(); chk("t4_g60", offer(trap_valid, trap_tid, trap_tt), offer(1, 60, 8'h09));
    tick(); chk("t4_g1", offer(trap_valid, trap_tid, trap_tt), offer(1, 1, 8'h0A));
    trap_ready = 0;
    rep(1, TT_IINST, 0); tick();
    rep(3, TT_PRIV, 0);  tick(); noexc();
    trap_ready = 1;
    tick(); chk("t4_ptr_g3", offer(trap_valid, trap_tid, trap_tt), offer(1, 3, 8'h03));
    tick(); chk("t4_ptr_g1", offer(trap_valid, trap_tid, trap_tt), offer(1, 1, 8'h02));
    tick(); chk("t4_idle", trap_valid, 0);

    // stability under backpressure, flush/report collisions
    trap_ready = 0;
    rep(9, TT_DIVZ, 0); tick(); noexc(); tick();
    chk("t5_offer", offer(trap_valid, trap_tid, trap_tt), offer(1, 9, 8'h2A));
    rep(9, TT_IAEX, 0); tick(); noexc();
    chk("t5_hold1", offer(trap_valid, trap_tid, trap_tt), offer(1, 9, 8'h2A));
    flush_valid = 1; flush_tid = 9; rep(9, TT_PRIV, 0); tick();
    flush_valid = 0; noexc();
    chk("t5_hold2", offer(trap_valid, trap_tid, trap_tt), offer(1, 9, 8'h2A));
    chk("t5_flushrep", pend_vec, 64'h200);
    rep(12, TT_TAG, 0); tick(); noexc();
    chk("t5_hold3", offer(trap_valid, trap_tid, trap_tt), offer(1, 9, 8'h2A));
    chk("t5_pend12", pend_vec, 64'h1200);
    flush_valid = 1; flush_tid = 12; tick(); flush_valid = 0;
    chk("t5_hold4", offer(trap_valid, trap_tid, trap_tt), offer(1, 9, 8'h2A));
    chk("t5_flushed", pend_vec, 64'h200);
    tick();
    chk("t5_hold5", offer(trap_valid, trap_tid, trap_tt), offer(1, 9, 8'h2A));
    trap_ready = 1;
    tick(); chk("t5_new9", offer(trap_valid, trap_tid, trap_tt), offer(1, 9, 8'h03));
    tick(); chk("t5_idle", trap_valid, 0);

    // reset mid-handshake
    trap_ready = 0;
    rep(20, TT_DIVZ, 0); tick();
    rep(21, TT_TAG, 0);  tick(); noexc();
    chk("t6_offer", offer(trap_valid, trap_tid, trap_tt), offer(1, 20, 8'h2A));
    chk("t6_pend", pend_vec, 64'h20_0000);
    rst = 1; tick(); rst = 0;
    chk("t6_offer0", offer(trap_valid, trap_tid, trap_tt), 64'h0);
    chk("t6_pend0", pend_vec, 64'h0);
    tick();
    chk("t6_stay", trap_valid, 0);

`ifdef SPARC_TRAP_CNT_EN
    cnt_tid = 0; tick();
    chk("c_zero", cnt_data, 16'h0);
    trap_ready = 1;
    for (int i = 0; i < 70010; i++) begin
      rep(0, TT_DIVZ, 0); tick();
    end
    noexc(); tick(); tick(); tick();
    chk("c_sat", cnt_data, 16'hFFFF);
    cnt_tid = 1; tick(); tick();
    chk("c_other", cnt_data, 16'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
